ray_sched: RTL and testbench
============================

RAY_SCHED -- requirements
Module: ray_sched

Interface
REQ-001 Parameter LAT, default 6, is the ray-step pipeline latency in cycles from input to output.
REQ-002 Parameter NUM_PIX, default 307200, is the number of rays per frame (640x480).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 frame_start  in  1  one-cycle pulse that starts a frame.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 frame_done  out  1  one-cycle pulse after the last ray of a frame retires.
REQ-008 ray_valid / ray_ready  in / out  1 / 1  new-ray handshake; a transfer occurs when both are high.
REQ-009 ray_pos_x/y/z  in  16 each  new-ray start position (unsigned fixed point, 7 fractional bits).
REQ-010 ray_slope_x/y/z  in  20 each, signed  new-ray slope.
REQ-011 ray_pixel_addr  in  20  new-ray pixel address.
REQ-012 pp_prepare_flag  out  1  prepare/flush control to the step pipeline.
REQ-013 pp_start_pos_x/y/z (16), pp_ray_slope_x/y/z (20 signed), pp_pixel_addr (20), pp_block_cnt (4)  out  step-pipeline inputs.
REQ-014 pp_end_pos_x/y/z (16), pp_ray_slope_out_x/y/z (20 signed), pp_pixel_addr_out (20), pp_block_cnt_out (4), pp_texture_addr (13), pp_next_en (1)  in  step-pipeline outputs.
REQ-015 pix_we (1), pix_addr (20), pix_tex_addr (13)  out  registered pixel write to the frame buffer; the sink never back-pressures.

Function
REQ-016 The FSM SHALL have states IDLE, PREP, RUN and DRAIN.
REQ-017 IDLE->PREP on frame_start; PREP->RUN after exactly LAT cycles in PREP; RUN->DRAIN when issued==NUM_PIX; DRAIN->IDLE when retired==NUM_PIX, with frame_done pulsed in the cycle IDLE is entered.
REQ-018 frame_start outside IDLE SHALL be ignored.
REQ-019 pp_prepare_flag SHALL be 1 in IDLE and PREP and 0 in RUN and DRAIN.
REQ-020 A LAT-bit valid shift register (vsr) SHALL shift in a 1 on each issued slot and a 0 on a bubble; pipeline output is valid when vsr[LAT-1]=1; vsr SHALL be cleared in IDLE and PREP.
REQ-021 Recirculate (same cycle, combinational mux) when vsr[LAT-1]=1 and pp_next_en=0: pp_start_pos=pp_end_pos, pp_ray_slope=pp_ray_slope_out, pp_pixel_addr=pp_pixel_addr_out, pp_block_cnt=pp_block_cnt_out.
REQ-022 ray_ready=1 only in RUN when no recirculation is occurring and issued<NUM_PIX; recirculation has strict priority over new rays.
REQ-023 On a new-ray transfer, pp inputs SHALL take ray_* values with pp_block_cnt=0, and issued SHALL increment.
REQ-024 When neither a recirculation nor a new-ray transfer occurs, pp data inputs SHALL be 0 and a bubble is recorded in vsr.
REQ-025 Retire when vsr[LAT-1]=1 and pp_next_en=1: the next cycle SHALL have pix_we=1, pix_addr=pp_pixel_addr_out and pix_tex_addr=pp_texture_addr, and retired SHALL increment.
REQ-026 Otherwise pix_we SHALL be 0; a retire and an injection in the same cycle are legal (the slot is reused).
REQ-027 issued and retired SHALL be 20-bit counters cleared on IDLE->PREP; neither may exceed NUM_PIX.
REQ-028 The step limit is enforced by the pipeline via pp_next_en; this block SHALL NOT count steps.

Reset
REQ-029 On rst: state=IDLE; vsr, issued, retired=0; busy, frame_done, ray_ready, pix_we=0; pix_addr, pix_tex_addr=0; pp_prepare_flag=1; pp data outputs=0.
REQ-030 A rst asserted mid-frame SHALL abandon all in-flight rays, with no pix_we and no frame_done afterwards.

Structure
REQ-031 A package ray_sched_pkg SHALL hold the state enumeration, LAT/NUM_PIX defaults, and the position/slope/address width constants shared with the step pipeline.
REQ-032 The block SHALL contain no sub-module; the step pipeline is instantiated alongside it by the parent.

Verification (bench uses a behavioural LAT-cycle pipeline stub)
REQ-033 NUM_PIX=1, stub returns next_en=1 on first pass -> pix_we exactly LAT+1 cycles after the transfer, then frame_done; busy low afterwards.
REQ-034 NUM_PIX=1, stub returns next_en=0 twice then 1 -> pp_block_cnt issued as 0,1,2 at cycles T, T+LAT, T+2*LAT; a single pix_we at T+3*LAT+1.
REQ-035 NUM_PIX=8, ray_valid held high, every ray needs 2 passes -> ray_ready low exactly on recirculation cycles; 8 pix_we pulses; frame_done once.
REQ-036 frame_start pulsed during RUN -> no state change; counters unaffected.
REQ-037 rst asserted 3 cycles into RUN with 3 rays in flight -> all REQ-029 values next cycle; zero pix_we afterwards.
REQ-038 ray_valid low for 4 cycles mid-RUN -> 4 bubbles in vsr; no pix_we for those slots LAT+1 cycles later.

Source files
------------

// File: rtl/ray_sched_pkg.sv
// Shared types and widths for the ray scheduler and the ray-step pipeline it feeds.
// Position is unsigned fixed point with 7 fractional bits; slopes are signed.
package ray_sched_pkg;

  localparam int LAT_DEFAULT     = 6;
  localparam int NUM_PIX_DEFAULT = 307200;

  localparam int POS_W   = 16;
  localparam int SLOPE_W = 20;
  localparam int ADDR_W  = 20;
  localparam int BLK_W   = 4;
  localparam int TEX_W   = 13;
  localparam int CNT_W   = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // One pipeline slot worth of ray state.
  typedef struct packed {
    logic [POS_W-1:0]          pos_x;
    logic [POS_W-1:0]          pos_y;
    logic [POS_W-1:0]          pos_z;
    logic signed [SLOPE_W-1:0] slope_x;
    logic signed [SLOPE_W-1:0] slope_y;
    logic signed [SLOPE_W-1:0] slope_z;
    logic [ADDR_W-1:0]         pixel_addr;
    logic [BLK_W-1:0]          block_cnt;
  } ray_t;

endpackage

// File: rtl/ray_sched.sv
// Frame scheduler for the ray-step pipeline: injects new rays, recirculates unfinished
// rays with priority, and writes finished rays to the frame buffer.
module ray_sched
  import ray_sched_pkg::*;
#(
  parameter int LAT     = LAT_DEFAULT,
  parameter int NUM_PIX = NUM_PIX_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  output logic                      busy,
  output logic                      frame_done,
  input  logic                      ray_valid,
  output logic                      ray_ready,
  input  logic [POS_W-1:0]          ray_pos_x,
  input  logic [POS_W-1:0]          ray_pos_y,
  input  logic [POS_W-1:0]          ray_pos_z,
  input  logic signed [SLOPE_W-1:0] ray_slope_x,
  input  logic signed [SLOPE_W-1:0] ray_slope_y,
  input  logic signed [SLOPE_W-1:0] ray_slope_z,
  input  logic [ADDR_W-1:0]         ray_pixel_addr,
  output logic                      pp_prepare_flag,
  output logic [POS_W-1:0]          pp_start_pos_x,
  output logic [POS_W-1:0]          pp_start_pos_y,
  output logic [POS_W-1:0]          pp_start_pos_z,
  output logic signed [SLOPE_W-1:0] pp_ray_slope_x,
  output logic signed [SLOPE_W-1:0] pp_ray_slope_y,
  output logic signed [SLOPE_W-1:0] pp_ray_slope_z,
  output logic [ADDR_W-1:0]         pp_pixel_addr,
  output logic [BLK_W-1:0]          pp_block_cnt,
  input  logic [POS_W-1:0]          pp_end_pos_x,
  input  logic [POS_W-1:0]          pp_end_pos_y,
  input  logic [POS_W-1:0]          pp_end_pos_z,
  input  logic signed [SLOPE_W-1:0] pp_ray_slope_out_x,
  input  logic signed [SLOPE_W-1:0] pp_ray_slope_out_y,
  input  logic signed [SLOPE_W-1:0] pp_ray_slope_out_z,
  input  logic [ADDR_W-1:0]         pp_pixel_addr_out,
  input  logic [BLK_W-1:0]          pp_block_cnt_out,
  input  logic [TEX_W-1:0]          pp_texture_addr,
  input  logic                      pp_next_en,
  output logic                      pix_we,
  output logic [ADDR_W-1:0]         pix_addr,
  output logic [TEX_W-1:0]          pix_tex_addr
);

  localparam int                PREP_W    = $clog2(LAT + 1);
  localparam logic [PREP_W-1:0] PREP_LAST = PREP_W'(LAT - 1);
  localparam logic [CNT_W-1:0]  NUM_PIX_C = CNT_W'(NUM_PIX);

  state_e            state_q, state_d;
  logic [LAT-1:0]    vsr_q, vsr_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [PREP_W-1:0] prep_cnt_q, prep_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              pix_we_q, pix_we_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [TEX_W-1:0]  pix_tex_q, pix_tex_d;

  logic active;
  logic head_valid;
  logic recirc;
  logic retire;
  logic accept;
  ray_t new_ray;
  ray_t back_ray;
  ray_t pp_ray;

  // Slot arbitration: a valid slot that is not finished must go straight back in.
  always_comb begin
    active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    head_valid = active && vsr_q[LAT-1];
    recirc     = head_valid && !pp_next_en;
    retire     = head_valid && pp_next_en && (retired_q < NUM_PIX_C);
    ray_ready  = (state_q == ST_RUN) && !recirc && (issued_q < NUM_PIX_C);
    accept     = ray_ready && ray_valid;
  end

  always_comb begin
    new_ray = '{
      pos_x:      ray_pos_x,
      pos_y:      ray_pos_y,
      pos_z:      ray_pos_z,
      slope_x:    ray_slope_x,
      slope_y:    ray_slope_y,
      slope_z:    ray_slope_z,
      pixel_addr: ray_pixel_addr,
      block_cnt:  '0
    };
    back_ray = '{
      pos_x:      pp_end_pos_x,
      pos_y:      pp_end_pos_y,
      pos_z:      pp_end_pos_z,
      slope_x:    pp_ray_slope_out_x,
      slope_y:    pp_ray_slope_out_y,
      slope_z:    pp_ray_slope_out_z,
      pixel_addr: pp_pixel_addr_out,
      block_cnt:  pp_block_cnt_out
    };
    if (recirc) begin
      pp_ray = back_ray;
    end else if (accept) begin
      pp_ray = new_ray;
    end else begin
      pp_ray = '0;
    end
  end

  assign pp_start_pos_x  = pp_ray.pos_x;
  assign pp_start_pos_y  = pp_ray.pos_y;
  assign pp_start_pos_z  = pp_ray.pos_z;
  assign pp_ray_slope_x  = pp_ray.slope_x;
  assign pp_ray_slope_y  = pp_ray.slope_y;
  assign pp_ray_slope_z  = pp_ray.slope_z;
  assign pp_pixel_addr   = pp_ray.pixel_addr;
  assign pp_block_cnt    = pp_ray.block_cnt;

  assign busy            = (state_q != ST_IDLE);
  assign pp_prepare_flag = (state_q == ST_IDLE) || (state_q == ST_PREP);
  assign frame_done      = frame_done_q;
  assign pix_we          = pix_we_q;
  assign pix_addr        = pix_addr_q;
  assign pix_tex_addr    = pix_tex_q;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    vsr_d        = vsr_q;
    issued_d     = issued_q;
    retired_d    = retired_q;
    prep_cnt_d   = prep_cnt_q;
    frame_done_d = 1'b0;
    pix_we_d     = retire;
    pix_addr_d   = retire ? pp_pixel_addr_out : pix_addr_q;
    pix_tex_d    = retire ? pp_texture_addr : pix_tex_q;

    unique case (state_q)
      ST_IDLE: begin
        vsr_d = '0;
        if (frame_start) begin
          state_d    = ST_PREP;
          issued_d   = '0;
          retired_d  = '0;
          prep_cnt_d = '0;
        end
      end
      ST_PREP: begin
        vsr_d      = '0;
        prep_cnt_d = prep_cnt_q + 1'b1;
        if (prep_cnt_q == PREP_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        vsr_d = LAT'({vsr_q, recirc | accept});
        if (accept) begin
          issued_d = issued_q + 1'b1;
        end
        if (retire) begin
          retired_d = retired_q + 1'b1;
        end
        if (state_q == ST_RUN) begin
          if (issued_q == NUM_PIX_C) begin
            state_d = ST_DRAIN;
          end
        end else if (retired_q == NUM_PIX_C) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vsr_q        <= '0;
      issued_q     <= '0;
      retired_q    <= '0;
      prep_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      pix_we_q     <= 1'b0;
      pix_addr_q   <= '0;
      pix_tex_q    <= '0;
    end else begin
      state_q      <= state_d;
      vsr_q        <= vsr_d;
      issued_q     <= issued_d;
      retired_q    <= retired_d;
      prep_cnt_q   <= prep_cnt_d;
      frame_done_q <= frame_done_d;
      pix_we_q     <= pix_we_d;
      pix_addr_q   <= pix_addr_d;
      pix_tex_q    <= pix_tex_d;
    end
  end

endmodule

// File: tb/tb_ray_sched.sv
// Bench for ray_sched: one single-ray frame instance and one 8-ray instance, each fed by a
// behavioural LAT-stage pipeline stub; expectations come from ray timing arithmetic.
module tb_ray_sched;
  import ray_sched_pkg::*;

  localparam int LAT = 6;

  typedef struct packed {
    logic [15:0] px, py, pz;
    logic [19:0] sx, sy, sz;
    logic [19:0] addr;
    logic [3:0]  blk;
  } pp_t;

  typedef struct {
    int  t;
    int  p;
    pp_t r;
  } ray_rec_t;

  typedef struct {
    bit big;
    int vmode;
    bit rnd;
    int passes;
    bit spam;
    int exp_we;
    int exp_fd;
    int exp_off;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  bit big_sel      = 1'b0;
  bit rand_passes  = 1'b0;
  int fixed_passes = 1;

  logic [15:0] r_px, r_py, r_pz;
  logic [19:0] r_sx, r_sy, r_sz, r_addr;
  logic fs1, fs8, rv1, rv8;

  // dut1 signals
  logic b1, fd1, rdy1, prep1, we1;
  logic [15:0] spx1, spy1, spz1;
  logic [19:0] ssx1, ssy1, ssz1, sad1, pa1;
  logic [3:0]  sbk1;
  logic [12:0] pt1, tex1;
  logic        ne1;
  pp_t pi1, po1;
  pp_t pipe1 [LAT];

  // dut8 signals
  logic b8, fd8, rdy8, prep8, we8;
  logic [15:0] spx8, spy8, spz8;
  logic [19:0] ssx8, ssy8, ssz8, sad8, pa8;
  logic [3:0]  sbk8;
  logic [12:0] pt8, tex8;
  logic        ne8;
  pp_t pi8, po8;
  pp_t pipe8 [LAT];

  ray_sched #(.LAT(LAT), .NUM_PIX(1)) dut1 (
    .clk(clk), .rst(rst), .frame_start(fs1), .busy(b1), .frame_done(fd1),
    .ray_valid(rv1), .ray_ready(rdy1),
    .ray_pos_x(r_px), .ray_pos_y(r_py), .ray_pos_z(r_pz),
    .ray_slope_x(r_sx), .ray_slope_y(r_sy), .ray_slope_z(r_sz),
    .ray_pixel_addr(r_addr), .pp_prepare_flag(prep1),
    .pp_start_pos_x(spx1), .pp_start_pos_y(spy1), .pp_start_pos_z(spz1),
    .pp_ray_slope_x(ssx1), .pp_ray_slope_y(ssy1), .pp_ray_slope_z(ssz1),
    .pp_pixel_addr(sad1), .pp_block_cnt(sbk1),
    .pp_end_pos_x(po1.px), .pp_end_pos_y(po1.py), .pp_end_pos_z(po1.pz),
    .pp_ray_slope_out_x(po1.sx), .pp_ray_slope_out_y(po1.sy), .pp_ray_slope_out_z(po1.sz),
    .pp_pixel_addr_out(po1.addr), .pp_block_cnt_out(po1.blk),
    .pp_texture_addr(tex1), .pp_next_en(ne1),
    .pix_we(we1), .pix_addr(pa1), .pix_tex_addr(pt1)
  );

  ray_sched #(.LAT(LAT), .NUM_PIX(8)) dut8 (
    .clk(clk), .rst(rst), .frame_start(fs8), .busy(b8), .frame_done(fd8),
    .ray_valid(rv8), .ray_ready(rdy8),
    .ray_pos_x(r_px), .ray_pos_y(r_py), .ray_pos_z(r_pz),
    .ray_slope_x(r_sx), .ray_slope_y(r_sy), .ray_slope_z(r_sz),
    .ray_pixel_addr(r_addr), .pp_prepare_flag(prep8),
    .pp_start_pos_x(spx8), .pp_start_pos_y(spy8), .pp_start_pos_z(spz8),
    .pp_ray_slope_x(ssx8), .pp_ray_slope_y(ssy8), .pp_ray_slope_z(ssz8),
    .pp_pixel_addr(sad8), .pp_block_cnt(sbk8),
    .pp_end_pos_x(po8.px), .pp_end_pos_y(po8.py), .pp_end_pos_z(po8.pz),
    .pp_ray_slope_out_x(po8.sx), .pp_ray_slope_out_y(po8.sy), .pp_ray_slope_out_z(po8.sz),
    .pp_pixel_addr_out(po8.addr), .pp_block_cnt_out(po8.blk),
    .pp_texture_addr(tex8), .pp_next_en(ne8),
    .pix_we(we8), .pix_addr(pa8), .pix_tex_addr(pt8)
  );

  assign pi1 = {spx1, spy1, spz1, ssx1, ssy1, ssz1, sad1, sbk1};
  assign pi8 = {spx8, spy8, spz8, ssx8, ssy8, ssz8, sad8, sbk8};

  // Stub behaviour: each pass advances x by one unit and bumps the block count; a ray
  // is finished once it has made the number of passes its address selects.
  function automatic pp_t stub_step(pp_t s);
    pp_t r = s;
    r.px  = s.px + 16'h0080;
    r.blk = s.blk + 4'd1;
    return r;
  endfunction

  function automatic logic [12:0] tex_of(logic [19:0] a);
    return a[12:0] ^ 13'h0a5a;
  endfunction

  function automatic int passes_of(logic [19:0] a);
    return rand_passes ? 1 + int'(a % 3) : fixed_passes;
  endfunction

  always @(posedge clk) begin
    pipe1[0] <= pi1;
    pipe8[0] <= pi8;
    for (int i = 1; i < LAT; i++) begin
      pipe1[i] <= pipe1[i-1];
      pipe8[i] <= pipe8[i-1];
    end
  end

  always_comb begin
    po1  = stub_step(pipe1[LAT-1]);
    tex1 = tex_of(pipe1[LAT-1].addr);
    ne1  = (int'(pipe1[LAT-1].blk) + 1) >= passes_of(pipe1[LAT-1].addr);
    po8  = stub_step(pipe8[LAT-1]);
    tex8 = tex_of(pipe8[LAT-1].addr);
    ne8  = (int'(pipe8[LAT-1].blk) + 1) >= passes_of(pipe8[LAT-1].addr);
  end

  logic        v_busy, v_fd, v_rdy, v_prep, v_we;
  logic [19:0] v_pa;
  logic [12:0] v_pt;
  pp_t         v_pp;
  always_comb begin
    v_busy = big_sel ? b8 : b1;
    v_fd   = big_sel ? fd8 : fd1;
    v_rdy  = big_sel ? rdy8 : rdy1;
    v_prep = big_sel ? prep8 : prep1;
    v_we   = big_sel ? we8 : we1;
    v_pa   = big_sel ? pa8 : pa1;
    v_pt   = big_sel ? pt8 : pt1;
    v_pp   = big_sel ? pi8 : pi1;
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic new_ray_data();
    r_px   = 16'($urandom);
    r_py   = 16'($urandom);
    r_pz   = 16'($urandom);
    r_sx   = 20'($urandom);
    r_sy   = 20'($urandom);
    r_sz   = 20'($urandom);
    r_addr = 20'($urandom);
  endtask

  function automatic bit valid_for(int vmode, int c, int rs);
    case (vmode)
      1:       return $urandom_range(3) != 0;
      2:       return !(c >= rs + 1 && c < rs + 5);
      default: return 1'b1;
    endcase
  endfunction

  // One complete frame on the selected instance, checked cycle by cycle against ray timing:
  // a ray accepted at cycle t with p passes re-enters at t+k*LAT and is written at t+p*LAT+1.
  task automatic run_frame(input vec_t v, output int n_we, output int n_fd, output int first_off);
    ray_rec_t rays[$];
    int  num      = v.big ? 8 : 1;
    int  rs       = LAT + 1;
    int  n_iss    = 0;
    int  fd_cyc   = 0;
    int  first_t  = -1;
    bit  all_iss  = 1'b0;
    bit  done     = 1'b0;
    bit  fs, rv;
    n_we = 0; n_fd = 0; first_off = -1;
    big_sel      = v.big;
    rand_passes  = v.rnd;
    fixed_passes = v.passes;
    for (int c = 0; c < 3000 && !done; c++) begin
      bit  exp_recirc, exp_we, exp_rdy, exp_fd, exp_busy, exp_prep;
      logic [19:0] exp_pa;
      pp_t exp_pp;
      @(posedge clk);
      #1;
      fs = (c == 0) || (v.spam && c > rs && (c % 5) == 0 && (!all_iss || c < fd_cyc));
      rv = valid_for(v.vmode, c, rs);
      new_ray_data();
      fs1 = fs & !v.big;
      fs8 = fs & v.big;
      rv1 = rv & !v.big;
      rv8 = rv & v.big;
      @(negedge clk);
      exp_recirc = 1'b0;
      exp_we     = 1'b0;
      exp_pa     = '0;
      exp_pp     = '0;
      foreach (rays[i]) begin
        int d = c - rays[i].t;
        if (d > 0 && (d % LAT) == 0 && (d / LAT) < rays[i].p) begin
          exp_recirc    = 1'b1;
          exp_pp        = rays[i].r;
          exp_pp.px     = rays[i].r.px + 16'((d / LAT) * 128);
          exp_pp.blk    = 4'(d / LAT);
        end
        if (d == rays[i].p * LAT + 1) begin
          exp_we = 1'b1;
          exp_pa = rays[i].r.addr;
        end
      end
      exp_rdy  = (c >= rs) && (n_iss < num) && !exp_recirc;
      exp_fd   = all_iss && (c == fd_cyc);
      exp_busy = (c >= 1) && !(all_iss && c >= fd_cyc);
      exp_prep = !((c >= rs) && !(all_iss && c >= fd_cyc));
      check("ray_ready", v_rdy, exp_rdy);
      check("pix_we", v_we, exp_we);
      check("frame_done", v_fd, exp_fd);
      check("busy", v_busy, exp_busy);
      check("pp_prepare_flag", v_prep, exp_prep);
      if (exp_we) begin
        check("pix_addr", v_pa, exp_pa);
        check("pix_tex_addr", v_pt, tex_of(exp_pa));
      end
      if (exp_recirc) begin
        check("recirc_pp_inputs", v_pp, exp_pp);
      end else if (exp_rdy && rv) begin
        pp_t nr = {r_px, r_py, r_pz, r_sx, r_sy, r_sz, r_addr, 4'd0};
        check("new_ray_pp_inputs", v_pp, nr);
        rays.push_back('{t: c, p: passes_of(r_addr), r: nr});
        if (first_t < 0) first_t = c;
        n_iss++;
        if (n_iss == num) begin
          all_iss = 1'b1;
          foreach (rays[i]) begin
            if (rays[i].t + rays[i].p * LAT + 2 > fd_cyc) fd_cyc = rays[i].t + rays[i].p * LAT + 2;
          end
        end
      end else begin
        check("bubble_pp_inputs", v_pp, '0);
      end
      if (v_we) begin
        n_we++;
        if (first_off < 0) first_off = c - first_t;
      end
      if (v_fd) n_fd++;
      done = all_iss && (c >= fd_cyc + 2);
    end
    check("frame_completed_in_budget", done, 1'b1);
    fs1 = 1'b0; fs8 = 1'b0;
  endtask

  vec_t tbl [8];

  initial begin
    int n_we, n_fd, off;
    tbl[0] = '{0, 0, 0, 1, 0, 1, 1, LAT + 1};      // single ray, one pass
    tbl[1] = '{0, 0, 0, 3, 0, 1, 1, 3 * LAT + 1};  // single ray, three passes
    tbl[2] = '{0, 1, 0, 2, 0, 1, 1, 2 * LAT + 1};  // single ray, ragged valid
    tbl[3] = '{1, 0, 0, 2, 0, 8, 1, 2 * LAT + 1};  // valid held, two passes each
    tbl[4] = '{1, 2, 0, 1, 0, 8, 1, LAT + 1};      // four-cycle valid gap
    tbl[5] = '{1, 0, 0, 1, 1, 8, 1, LAT + 1};      // frame_start noise while busy
    tbl[6] = '{1, 1, 1, 0, 0, 8, 1, -1};           // random valid and pass counts
    tbl[7] = '{1, 1, 1, 0, 1, 8, 1, -1};

    rst = 1'b1;
    fs1 = 1'b0; fs8 = 1'b0; rv1 = 1'b0; rv8 = 1'b0;
    new_ray_data();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {b1, b8}, 2'b00);
    check("rst_frame_done", {fd1, fd8}, 2'b00);
    check("rst_ray_ready", {rdy1, rdy8}, 2'b00);
    check("rst_pix_we", {we1, we8}, 2'b00);
    check("rst_pix_addr", {pa1, pt1, pa8, pt8}, '0);
    check("rst_prepare_flag", {prep1, prep8}, 2'b11);
    check("rst_pp_data", {pi1, pi8}, '0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i], n_we, n_fd, off);
      check($sformatf("row%0d_pix_we_count", i), n_we, tbl[i].exp_we);
      check($sformatf("row%0d_frame_done_count", i), n_fd, tbl[i].exp_fd);
      if (tbl[i].exp_off >= 0) check($sformatf("row%0d_first_write_latency", i), off, tbl[i].exp_off);
    end

    // Reset three cycles into RUN with three rays in flight on the 8-ray instance.
    big_sel = 1'b1; rand_passes = 1'b0; fixed_passes = 3;
    for (int c = 0; c <= LAT + 4; c++) begin
      @(posedge clk);
      #1;
      fs8 = (c == 0);
      rv8 = 1'b1;
      new_ray_data();
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", b8, 1'b0);
    check("midrst_frame_done", fd8, 1'b0);
    check("midrst_ray_ready", rdy8, 1'b0);
    check("midrst_pix_we", we8, 1'b0);
    check("midrst_pix_addr", {pa8, pt8}, '0);
    check("midrst_prepare_flag", prep8, 1'b1);
    check("midrst_pp_data", pi8, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("post_rst_no_write", {we8, fd8, b8}, 3'b000);
    end
    rv8 = 1'b0;

    run_frame(tbl[6], n_we, n_fd, off);
    check("recovery_pix_we_count", n_we, 8);
    check("recovery_frame_done_count", n_fd, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
